// File: rtl/glitch_check_monitor_pkg.sv
// rtl/glitch_check_monitor_pkg.sv - shared widths and FSM encoding for the glitch check monitor
package glitch_check_monitor_pkg;

  localparam int GCM_COUNT_WIDTH = 32;
  localparam int GCM_RUN_WIDTH   = 16;

  typedef enum logic [1:0] {
    GCM_IDLE  = 2'd0,
    GCM_CHECK = 2'd1,
    GCM_DONE  = 2'd2
  } gcm_state_e;

endpackage

// File: rtl/glitch_check_monitor_if.sv
// rtl/glitch_check_monitor_if.sv - control, sample and statistics bundle of the glitch check monitor
interface glitch_check_monitor_if #(
  parameter int pCOUNT_WIDTH = glitch_check_monitor_pkg::GCM_COUNT_WIDTH,
  parameter int pRUN_WIDTH   = glitch_check_monitor_pkg::GCM_RUN_WIDTH
);
  logic                    arm_i;
  logic [pCOUNT_WIDTH-1:0] window_i;
  logic                    glitch_out_i;
  logic                    expected_glitch_i;
  logic                    busy_o;
  logic                    done_o;
  logic                    error_o;
  logic [pCOUNT_WIDTH-1:0] error_count_o;
  logic [pCOUNT_WIDTH-1:0] first_error_cycle_o;
  logic [pRUN_WIDTH-1:0]   max_run_o;
  logic [pCOUNT_WIDTH-1:0] glitch_rises_o;
  logic [pCOUNT_WIDTH-1:0] expected_rises_o;

  modport master (
    output arm_i, window_i, glitch_out_i, expected_glitch_i,
    input  busy_o, done_o, error_o, error_count_o, first_error_cycle_o,
           max_run_o, glitch_rises_o, expected_rises_o
  );

  modport slave (
    input  arm_i, window_i, glitch_out_i, expected_glitch_i,
    output busy_o, done_o, error_o, error_count_o, first_error_cycle_o,
           max_run_o, glitch_rises_o, expected_rises_o
  );
endinterface

// File: rtl/glitch_check_monitor_sat_counter.sv
// rtl/glitch_check_monitor_sat_counter.sv - saturating event counter with synchronous clear
module gcm_sat_counter #(
  parameter int pWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [pWIDTH-1:0] count_o
);
  logic [pWIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && !(&count_q)) begin
      count_q <= count_q + pWIDTH'(1);
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/glitch_check_monitor.sv
// rtl/glitch_check_monitor.sv - compares a glitch output against its reference over an armed window
// and accumulates mismatch, run-length, first-error and edge statistics.
module glitch_check_monitor
  import glitch_check_monitor_pkg::*;
#(
  parameter int pCOUNT_WIDTH = GCM_COUNT_WIDTH,
  parameter int pRUN_WIDTH   = GCM_RUN_WIDTH
) (
  input  logic                  glitch_clk,
  input  logic                  reset_n,
  glitch_check_monitor_if.slave mon
);
  gcm_state_e              state_q;
  logic                    glitch_s_q, expected_s_q;
  logic                    prev_glitch_q, prev_expected_q;
  logic                    busy_q, done_q, error_q;
  logic [pCOUNT_WIDTH-1:0] idx_q, window_q, first_err_q;
  logic [pRUN_WIDTH-1:0]   max_run_q, max_run_d, run_plus;
  logic [pCOUNT_WIDTH-1:0] err_count, glitch_rises, expected_rises;
  logic [pRUN_WIDTH-1:0]   run_count;
  logic                    arm, in_check, mismatch, last_sample, not_first;

  // Sampling mid-cycle keeps edge skew between the two sources from reading as a mismatch.
  always_ff @(negedge glitch_clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_s_q   <= 1'b0;
      expected_s_q <= 1'b0;
    end else begin
      glitch_s_q   <= mon.glitch_out_i;
      expected_s_q <= mon.expected_glitch_i;
    end
  end

  always_comb begin
    arm         = mon.arm_i;
    in_check    = (state_q == GCM_CHECK) && !arm;
    mismatch    = glitch_s_q ^ expected_s_q;
    last_sample = (idx_q == window_q - pCOUNT_WIDTH'(1));
    not_first   = (idx_q != '0);
    run_plus    = (&run_count) ? run_count : run_count + pRUN_WIDTH'(1);
    max_run_d   = (run_plus > max_run_q) ? run_plus : max_run_q;
  end

  always_ff @(posedge glitch_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= GCM_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      idx_q           <= '0;
      window_q        <= '0;
      first_err_q     <= '1;
      max_run_q       <= '0;
      prev_glitch_q   <= 1'b0;
      prev_expected_q <= 1'b0;
    end else if (arm) begin
      window_q    <= mon.window_i;
      idx_q       <= '0;
      error_q     <= 1'b0;
      first_err_q <= '1;
      max_run_q   <= '0;
      if (mon.window_i != '0) begin
        state_q <= GCM_CHECK;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        state_q <= GCM_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end else if (state_q == GCM_CHECK) begin
      idx_q           <= idx_q + pCOUNT_WIDTH'(1);
      prev_glitch_q   <= glitch_s_q;
      prev_expected_q <= expected_s_q;
      if (mismatch) begin
        error_q   <= 1'b1;
        max_run_q <= max_run_d;
        if (!error_q) first_err_q <= idx_q;
      end
      if (last_sample) begin
        state_q <= GCM_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  gcm_sat_counter #(.pWIDTH(pCOUNT_WIDTH)) u_err_count (
    .clk(glitch_clk), .rst_n(reset_n), .clr_i(arm),
    .inc_i(in_check && mismatch), .count_o(err_count)
  );

  // A matching sample breaks the current run.
  gcm_sat_counter #(.pWIDTH(pRUN_WIDTH)) u_run_count (
    .clk(glitch_clk), .rst_n(reset_n), .clr_i(arm || (in_check && !mismatch)),
    .inc_i(in_check && mismatch), .count_o(run_count)
  );

  gcm_sat_counter #(.pWIDTH(pCOUNT_WIDTH)) u_glitch_rises (
    .clk(glitch_clk), .rst_n(reset_n), .clr_i(arm),
    .inc_i(in_check && not_first && glitch_s_q && !prev_glitch_q), .count_o(glitch_rises)
  );

  gcm_sat_counter #(.pWIDTH(pCOUNT_WIDTH)) u_expected_rises (
    .clk(glitch_clk), .rst_n(reset_n), .clr_i(arm),
    .inc_i(in_check && not_first && expected_s_q && !prev_expected_q), .count_o(expected_rises)
  );

  assign mon.busy_o              = busy_q;
  assign mon.done_o              = done_q;
  assign mon.error_o             = error_q;
  assign mon.error_count_o       = err_count;
  assign mon.first_error_cycle_o = first_err_q;
  assign mon.max_run_o           = max_run_q;
  assign mon.glitch_rises_o      = glitch_rises;
  assign mon.expected_rises_o    = expected_rises;
endmodule

// File: tb/tb_glitch_check_monitor.sv
// tb/tb_glitch_check_monitor.sv - directed self-checking bench for glitch_check_monitor
module tb_glitch_check_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  glitch_check_monitor_if #(.pCOUNT_WIDTH(32), .pRUN_WIDTH(16)) bus ();
  glitch_check_monitor_if #(.pCOUNT_WIDTH(4), .pRUN_WIDTH(3)) sbus ();

  glitch_check_monitor #(.pCOUNT_WIDTH(32), .pRUN_WIDTH(16)) u_dut (
    .glitch_clk(clk), .reset_n(rst_n), .mon(bus)
  );

  glitch_check_monitor #(.pCOUNT_WIDTH(4), .pRUN_WIDTH(3)) u_small (
    .glitch_clk(clk), .reset_n(rst_n), .mon(sbus)
  );

  // Caller is always 1ns after a rising edge.
  task automatic do_arm(input logic [31:0] w);
    bus.arm_i = 1'b1;
    bus.window_i = w;
    @(posedge clk); #1;
    bus.arm_i = 1'b0;
  endtask

  task automatic drive_window(input int n, input int mode);
    logic g, e;
    for (int i = 0; i < n; i++) begin
      e = 1'b0;
      g = 1'b0;
      case (mode)
        0: begin e = ((i / 4) % 2) == 1; g = e; end
        1: begin e = ((i / 4) % 2) == 1; g = e ^ ((i >= 10 && i <= 14) || i == 30); end
        2: begin e = 1'b0; g = (i < 10); end
        default: begin e = 1'b0; g = 1'b1; end
      endcase
      bus.glitch_out_i = g;
      bus.expected_glitch_i = e;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", bus.busy_o); end
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%0h exp=0", bus.done_o); end
    total++; if (bus.error_count_o !== 32'd0) begin bad++; $display("FAIL rst_errcnt got=%0h exp=0", bus.error_count_o); end
    total++; if (bus.first_error_cycle_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_first got=%0h exp=ffffffff", bus.first_error_cycle_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin bad++; $display("FAIL idle_after_rst got=%0h%0h exp=00", bus.busy_o, bus.done_o); end
  endtask

  task automatic test_reset_mid_check;
    do_arm(32'd100);
    drive_window(5, 2);
    total++; if (bus.error_count_o !== 32'd5) begin bad++; $display("FAIL midchk_errcnt got=%0d exp=5", bus.error_count_o); end
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL midchk_busy got=%0h exp=1", bus.busy_o); end
    rst_n = 1'b0;
    #2;
    total++; if (bus.error_count_o !== 32'd0) begin bad++; $display("FAIL rst2_errcnt got=%0d exp=0", bus.error_count_o); end
    total++; if (bus.error_o !== 1'b0) begin bad++; $display("FAIL rst2_error got=%0h exp=0", bus.error_o); end
    total++; if (bus.max_run_o !== 16'd0) begin bad++; $display("FAIL rst2_maxrun got=%0d exp=0", bus.max_run_o); end
    total++; if (bus.first_error_cycle_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst2_first got=%0h exp=ffffffff", bus.first_error_cycle_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst2_busy got=%0h exp=0", bus.busy_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_match_toggle;
    do_arm(32'd100);
    drive_window(99, 0);
    total++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin bad++; $display("FAIL tog_early got=%0h%0h exp=01", bus.done_o, bus.busy_o); end
    drive_window(1, 0);
    total++; if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL tog_done got=%0h%0h exp=10", bus.done_o, bus.busy_o); end
    total++; if (bus.error_count_o !== 32'd0) begin bad++; $display("FAIL tog_errcnt got=%0d exp=0", bus.error_count_o); end
    total++; if (bus.glitch_rises_o !== 32'd12) begin bad++; $display("FAIL tog_grises got=%0d exp=12", bus.glitch_rises_o); end
    total++; if (bus.expected_rises_o !== 32'd12) begin bad++; $display("FAIL tog_erises got=%0d exp=12", bus.expected_rises_o); end
    total++; if (bus.max_run_o !== 16'd0) begin bad++; $display("FAIL tog_maxrun got=%0d exp=0", bus.max_run_o); end
    total++; if (bus.first_error_cycle_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL tog_first got=%0h exp=ffffffff", bus.first_error_cycle_o); end
    drive_window(3, 3);
    total++; if (bus.error_count_o !== 32'd0 || bus.done_o !== 1'b1) begin bad++; $display("FAIL frozen got=%0d/%0h exp=0/1", bus.error_count_o, bus.done_o); end
  endtask

  task automatic test_mismatch_pattern;
    do_arm(32'd50);
    drive_window(50, 1);
    total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL pat_done got=%0h exp=1", bus.done_o); end
    total++; if (bus.error_count_o !== 32'd6) begin bad++; $display("FAIL pat_errcnt got=%0d exp=6", bus.error_count_o); end
    total++; if (bus.first_error_cycle_o !== 32'd10) begin bad++; $display("FAIL pat_first got=%0d exp=10", bus.first_error_cycle_o); end
    total++; if (bus.max_run_o !== 16'd5) begin bad++; $display("FAIL pat_maxrun got=%0d exp=5", bus.max_run_o); end
    total++; if (bus.error_o !== 1'b1) begin bad++; $display("FAIL pat_error got=%0h exp=1", bus.error_o); end
    total++; if (bus.glitch_rises_o !== 32'd8) begin bad++; $display("FAIL pat_grises got=%0d exp=8", bus.glitch_rises_o); end
    total++; if (bus.expected_rises_o !== 32'd6) begin bad++; $display("FAIL pat_erises got=%0d exp=6", bus.expected_rises_o); end
  endtask

  task automatic test_zero_window;
    do_arm(32'd0);
    total++; if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL zero_state got=%0h%0h exp=10", bus.done_o, bus.busy_o); end
    total++; if (bus.error_count_o !== 32'd0 || bus.error_o !== 1'b0) begin bad++; $display("FAIL zero_err got=%0d/%0h exp=0/0", bus.error_count_o, bus.error_o); end
    total++; if (bus.glitch_rises_o !== 32'd0 || bus.max_run_o !== 16'd0) begin bad++; $display("FAIL zero_stats got=%0d/%0d exp=0/0", bus.glitch_rises_o, bus.max_run_o); end
    total++; if (bus.first_error_cycle_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL zero_first got=%0h exp=ffffffff", bus.first_error_cycle_o); end
  endtask

  task automatic test_saturate;
    sbus.arm_i = 1'b1;
    sbus.window_i = 4'd15;
    @(posedge clk); #1;
    sbus.arm_i = 1'b0;
    sbus.glitch_out_i = 1'b1;
    sbus.expected_glitch_i = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    total++; if (sbus.busy_o !== 1'b1 || sbus.done_o !== 1'b0) begin bad++; $display("FAIL sat_early got=%0h%0h exp=10", sbus.busy_o, sbus.done_o); end
    @(posedge clk); #1;
    total++; if (sbus.done_o !== 1'b1) begin bad++; $display("FAIL sat_done got=%0h exp=1", sbus.done_o); end
    total++; if (sbus.error_count_o !== 4'd15) begin bad++; $display("FAIL sat_errcnt got=%0d exp=15", sbus.error_count_o); end
    total++; if (sbus.max_run_o !== 3'd7) begin bad++; $display("FAIL sat_maxrun got=%0d exp=7", sbus.max_run_o); end
    total++; if (sbus.first_error_cycle_o !== 4'd0) begin bad++; $display("FAIL sat_first got=%0d exp=0", sbus.first_error_cycle_o); end
  endtask

  task automatic test_rearm;
    do_arm(32'd40);
    drive_window(20, 2);
    total++; if (bus.error_count_o !== 32'd10) begin bad++; $display("FAIL rearm_pre got=%0d exp=10", bus.error_count_o); end
    bus.glitch_out_i = 1'b0;
    bus.expected_glitch_i = 1'b0;
    do_arm(32'd40);
    total++; if (bus.error_count_o !== 32'd0 || bus.error_o !== 1'b0) begin bad++; $display("FAIL rearm_clr got=%0d/%0h exp=0/0", bus.error_count_o, bus.error_o); end
    total++; if (bus.first_error_cycle_o !== 32'hFFFF_FFFF || bus.max_run_o !== 16'd0) begin bad++; $display("FAIL rearm_clr2 got=%0h/%0d exp=ffffffff/0", bus.first_error_cycle_o, bus.max_run_o); end
    total++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin bad++; $display("FAIL rearm_state got=%0h%0h exp=10", bus.busy_o, bus.done_o); end
    drive_window(39, 0);
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL rearm_early got=%0h exp=0", bus.done_o); end
    drive_window(1, 0);
    total++; if (bus.done_o !== 1'b1 || bus.error_count_o !== 32'd0) begin bad++; $display("FAIL rearm_done got=%0h/%0d exp=1/0", bus.done_o, bus.error_count_o); end
  endtask

  task automatic test_arm_on_last;
    do_arm(32'd3);
    drive_window(2, 3);
    total++; if (bus.error_count_o !== 32'd2) begin bad++; $display("FAIL last_pre got=%0d exp=2", bus.error_count_o); end
    do_arm(32'd5);
    total++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin bad++; $display("FAIL last_state got=%0h%0h exp=10", bus.busy_o, bus.done_o); end
    total++; if (bus.error_count_o !== 32'd0 || bus.error_o !== 1'b0) begin bad++; $display("FAIL last_clr got=%0d/%0h exp=0/0", bus.error_count_o, bus.error_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.arm_i = 1'b0;
    bus.window_i = '0;
    bus.glitch_out_i = 1'b0;
    bus.expected_glitch_i = 1'b0;
    sbus.arm_i = 1'b0;
    sbus.window_i = '0;
    sbus.glitch_out_i = 1'b0;
    sbus.expected_glitch_i = 1'b0;
    test_reset();
    test_reset_mid_check();
    test_match_toggle();
    test_mismatch_pattern();
    test_zero_window();
    test_saturate();
    test_rearm();
    test_arm_on_last();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
